// File: rtl/fir_mc_serial.sv
`default_nettype none
// ============================================================================
// Module   : fir_mc_serial
// Brief    : Time-multiplexed multi-channel FIR. Coefficients are runtime
//            programmable and one serial MAC is shared by all channels.
//            Results are rounded half-up and saturated. Valid/ready
//            handshakes are used on both the input and the output side.
// Revision : 1.0 - initial release
// ============================================================================
module fir_mc_serial #(
  parameter int IN_WIDTH    = 8,
  parameter int COEFF_WIDTH = 8,
  parameter int OUT_WIDTH   = 9,
  parameter int TAPS        = 4,
  parameter int CHANNELS    = 2,
  parameter int ROUND_BITS  = 2
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              in_valid,
  output logic                                              in_ready,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] in_chan,
  input  logic [IN_WIDTH-1:0]                               in_data,
  output logic                                              out_valid,
  input  logic                                              out_ready,
  output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] out_chan,
  output logic [OUT_WIDTH-1:0]                              out_data,
  output logic                                              out_sat,
  input  logic                                              coef_we,
  input  logic [((TAPS > 1) ? $clog2(TAPS) : 1)-1:0]         coef_addr,
  input  logic [COEFF_WIDTH-1:0]                            coef_data
);

  localparam int c_CHW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int c_TW    = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int c_PW    = IN_WIDTH + COEFF_WIDTH;
  localparam int c_ACC_W = c_PW + $clog2(TAPS) + 1;
  // One guard bit so adding the rounding constant can never wrap.
  localparam int c_RW    = c_ACC_W + 1;

  localparam logic signed [c_RW-1:0] c_OMAX = c_RW'((2 ** (OUT_WIDTH - 1)) - 1);
  localparam logic signed [c_RW-1:0] c_OMIN = c_RW'(-(2 ** (OUT_WIDTH - 1)));

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic signed [IN_WIDTH-1:0]    r_tap  [CHANNELS][TAPS];
  logic signed [COEFF_WIDTH-1:0] r_coef [TAPS];
  logic signed [c_ACC_W-1:0]     r_acc;
  logic [c_TW-1:0]               r_idx;
  logic [c_CHW-1:0]              r_ch;
  logic [OUT_WIDTH-1:0]          r_out_data;
  logic [c_CHW-1:0]              r_out_chan;
  logic                          r_out_sat;

  logic                          w_chan_ok;
  logic                          w_addr_ok;
  logic                          w_start;
  logic                          w_last;
  logic signed [IN_WIDTH-1:0]    w_tap_sel;
  logic signed [COEFF_WIDTH-1:0] w_coef_sel;
  logic signed [c_PW-1:0]        w_prod;
  logic signed [c_ACC_W-1:0]     w_acc_next;
  logic signed [c_RW-1:0]        w_acc_ext;
  logic signed [c_RW-1:0]        w_rnd;
  logic [OUT_WIDTH-1:0]          w_clip;
  logic                          w_sat;

  // Index range checks collapse to constants when the field width exactly
  // covers the channel/tap count, so the comparison is only built otherwise.
  generate
    if ((1 << c_CHW) == CHANNELS) begin : g_chan_full
      assign w_chan_ok = 1'b1;
    end else begin : g_chan_chk
      assign w_chan_ok = (int'(in_chan) < CHANNELS);
    end
    if ((1 << c_TW) == TAPS) begin : g_addr_full
      assign w_addr_ok = 1'b1;
    end else begin : g_addr_chk
      assign w_addr_ok = (int'(coef_addr) < TAPS);
    end
  endgenerate

  // A sample with an out-of-range channel is consumed but never starts a MAC.
  assign w_start = in_valid && (r_state == S_IDLE) && w_chan_ok;
  assign w_last  = (r_idx == c_TW'(TAPS - 1));

  assign w_tap_sel  = r_tap[r_ch][r_idx];
  assign w_coef_sel = r_coef[r_idx];
  assign w_prod     = w_tap_sel * w_coef_sel;
  assign w_acc_next = r_acc + {{(c_ACC_W - c_PW){w_prod[c_PW-1]}}, w_prod};
  assign w_acc_ext  = {w_acc_next[c_ACC_W-1], w_acc_next};

  // Round half-up by adding half an output LSB, then arithmetic shift.
  generate
    if (ROUND_BITS > 0) begin : g_round
      localparam logic signed [c_RW-1:0] c_HALF = c_RW'(1) <<< (ROUND_BITS - 1);
      logic signed [c_RW-1:0] w_sum;
      assign w_sum = w_acc_ext + c_HALF;
      assign w_rnd = w_sum >>> ROUND_BITS;
    end else begin : g_no_round
      assign w_rnd = w_acc_ext;
    end
  endgenerate

  // Saturate the rounded value into the signed output range.
  always_comb begin
    w_sat  = 1'b0;
    w_clip = w_rnd[OUT_WIDTH-1:0];
    if (w_rnd > c_OMAX) begin
      w_clip = c_OMAX[OUT_WIDTH-1:0];
      w_sat  = 1'b1;
    end else if (w_rnd < c_OMIN) begin
      w_clip = c_OMIN[OUT_WIDTH-1:0];
      w_sat  = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and handshake outputs; no input is accepted while busy.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (w_start) begin
          w_state_next = S_MAC;
        end
      end
      S_MAC: begin
        if (w_last) begin
          w_state_next = S_OUT;
        end
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Shift the addressed channel's delay line; other channels are untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        for (int k = 0; k < TAPS; k++) begin
          r_tap[c][k] <= '0;
        end
      end
    end else if (w_start) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (in_chan == c_CHW'(c)) begin
          r_tap[c][0] <= in_data;
          for (int k = 1; k < TAPS; k++) begin
            r_tap[c][k] <= r_tap[c][k-1];
          end
        end
      end
    end
  end

  // Coefficient bank; a MAC reading the written tap in the same cycle sees the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) begin
        r_coef[i] <= COEFF_WIDTH'(i + 1);
      end
    end else if (coef_we && w_addr_ok) begin
      r_coef[coef_addr] <= coef_data;
    end
  end

  // Serial MAC; the final sum is rounded, clipped and captured on the last tap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc      <= '0;
      r_idx      <= '0;
      r_ch       <= '0;
      r_out_data <= '0;
      r_out_chan <= '0;
      r_out_sat  <= 1'b0;
    end else if (w_start) begin
      r_acc <= '0;
      r_idx <= '0;
      r_ch  <= in_chan;
    end else if (r_state == S_MAC) begin
      r_acc <= w_acc_next;
      r_idx <= r_idx + c_TW'(1);
      if (w_last) begin
        r_out_data <= w_clip;
        r_out_chan <= r_ch;
        r_out_sat  <= w_sat;
      end
    end
  end

  assign out_data = r_out_data;
  assign out_chan = r_out_chan;
  assign out_sat  = r_out_sat;

endmodule
`default_nettype wire

// File: tb/tb_fir_mc_serial.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_mc_serial
// Brief    : Directed self-checking bench for fir_mc_serial with default
//            parameters (4 taps, 2 channels, 2 rounding bits, 9-bit output).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_mc_serial;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [0:0] in_chan;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [0:0] out_chan;
  logic [8:0] out_data;
  logic       out_sat;
  logic       coef_we;
  logic [1:0] coef_addr;
  logic [7:0] coef_data;

  int n_tests = 0;
  int n_fail  = 0;
  int lat;
  int seen;

  fir_mc_serial dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_chan   (in_chan),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_chan  (out_chan),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Waits for in_ready, presents one sample across a single rising edge.
  task automatic send(input int ch, input int d);
    int n;
    n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", int'(in_ready), 1);
    in_valid = 1'b1;
    in_chan  = 1'(ch);
    in_data  = 8'(d);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'd0;
  endtask

  task automatic write_coef(input int a, input int d);
    coef_we   = 1'b1;
    coef_addr = 2'(a);
    coef_data = 8'(d);
    @(negedge clk);
    coef_we   = 1'b0;
  endtask

  // Waits for out_valid, optionally stalls the sink, checks, then handshakes.
  task automatic recv(input string tag, input int ed, input int ec, input int es,
                      input int hold, output int latency);
    latency = 0;
    while (!out_valid && latency < 40) begin
      @(negedge clk);
      latency++;
    end
    check({tag, "_valid"}, int'(out_valid), 1);
    check({tag, "_data"}, int'($signed(out_data)), ed);
    check({tag, "_chan"}, int'(out_chan), ec);
    check({tag, "_sat"}, int'(out_sat), es);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_chan  = 1'b1;
      in_data  = 8'd99;
      @(negedge clk);
      check({tag, "_hold_data"}, int'($signed(out_data)), ed);
      check({tag, "_hold_chan"}, int'(out_chan), ec);
      check({tag, "_hold_valid"}, int'(out_valid), 1);
      check({tag, "_hold_in_ready"}, int'(in_ready), 0);
    end
    in_valid  = 1'b0;
    in_data   = 8'd0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_chan   = 1'b0;
    in_data   = 8'd0;
    out_ready = 1'b0;
    coef_we   = 1'b0;
    coef_addr = 2'd0;
    coef_data = 8'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_chan", int'(out_chan), 0);
    check("rst_out_sat", int'(out_sat), 0);

    // Impulse response with default coefficients 1,2,3,4
    send(0, 100);
    recv("imp0", 25, 0, 0, 0, lat);
    check("latency", lat, 4);
    send(0, 0);
    recv("imp1", 50, 0, 0, 0, lat);
    send(0, 0);
    recv("imp2", 75, 0, 0, 0, lat);
    send(0, 0);
    recv("imp3", 100, 0, 0, 0, lat);
    send(0, 0);
    recv("imp4", 0, 0, 0, 0, lat);

    // Positive then negative saturation
    send(0, 127);
    recv("pos0", 32, 0, 0, 0, lat);
    send(0, 127);
    recv("pos1", 95, 0, 0, 0, lat);
    send(0, 127);
    recv("pos2", 191, 0, 0, 0, lat);
    send(0, 127);
    recv("pos3", 255, 0, 1, 0, lat);
    send(0, -128);
    recv("neg0", 254, 0, 0, 0, lat);
    send(0, -128);
    recv("neg1", 126, 0, 0, 0, lat);
    send(0, -128);
    recv("neg2", -65, 0, 0, 0, lat);
    send(0, -128);
    recv("neg3", -256, 0, 1, 0, lat);

    // Channel isolation
    do_reset();
    send(0, 100);
    recv("iso0", 25, 0, 0, 0, lat);
    send(1, 40);
    recv("iso1", 10, 1, 0, 0, lat);
    send(0, 0);
    recv("iso2", 50, 0, 0, 0, lat);

    // Output backpressure; in_data presented during stall must be ignored
    send(1, 0);
    recv("stall", 20, 1, 0, 5, lat);
    send(1, 0);
    recv("post_stall", 30, 1, 0, 0, lat);

    // Programmed coefficients and write during MAC index 0
    do_reset();
    write_coef(0, 4);
    write_coef(1, 0);
    write_coef(2, 0);
    write_coef(3, 0);
    send(0, 64);
    recv("cf0", 64, 0, 0, 0, lat);
    send(0, 0);
    recv("cf1", 0, 0, 0, 0, lat);
    send(0, 10);
    write_coef(0, 1);
    recv("cf_old", 10, 0, 0, 0, lat);
    send(0, 8);
    recv("cf_new", 2, 0, 0, 0, lat);

    // Reset during the second MAC cycle
    send(0, 100);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check("midrst_no_out", seen, 0);
    check("midrst_in_ready", int'(in_ready), 1);
    send(0, 100);
    recv("midrst0", 25, 0, 0, 0, lat);
    send(0, 0);
    recv("midrst1", 50, 0, 0, 0, lat);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
